// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave endpoint backed by a word-wide SRAM.
//   Latency: first R beat the cycle after the AR handshake; B the cycle after the last W beat.
//   Backpressure: R and B hold stable until rready/bready. One outstanding burst per direction.
// Ports: clk/rst (sync, active-high), s_axi_ar*/r* read channel, s_axi_aw*/w*/b* write channels.
// Optional build macro AXI_MEM_ERR_RESP_EN: out-of-range beats give SLVERR, and bad wlast gives SLVERR.
// Without the macro, addresses wrap modulo the memory size and every response is OKAY.
module axi_slave_mem #(
  parameter int WIDTH      = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [WIDTH-1:0]      s_axi_wdata,
  input  logic [WIDTH/8-1:0]    s_axi_wstrb,
  input  logic                  s_axi_wlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp
);

  localparam int STRB_W = WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Address of the beat after `a`. WRAP keeps the upper bits of the wrap-aligned
  // base and lets only the in-window bits advance; illegal WRAP lengths fall to INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, incr, wmask;
    step  = ADDR_WIDTH'(1) << size;
    incr  = (a & ~(step - ADDR_WIDTH'(1))) + step;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr = incr;
    if (burst == 2'b00) begin
      next_addr = a;
    end else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      next_addr = (a & ~wmask) | (incr & wmask);
    end
  endfunction

  logic [WIDTH-1:0] mem_q [MEM_WORDS];

  // Read path state
  logic [0:0]            rstate_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [WIDTH-1:0]      rdata_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rcnt_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;

  // Write path state
  logic [1:0]            wstate_q;
  logic                  awready_q, wready_q, bvalid_q, werr_q;
  logic [ID_WIDTH-1:0]   wid_q, bid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;

  logic [IDX_W-1:0] ar_idx, rn_idx, w_idx;
  logic             ar_oor, rn_oor, w_oor, w_bad, w_fire, mem_we;

  assign raddr_d = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
  assign waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
  assign ar_idx  = s_axi_araddr[IDX_W+OFF_W-1:OFF_W];
  assign rn_idx  = raddr_d[IDX_W+OFF_W-1:OFF_W];
  assign w_idx   = waddr_q[IDX_W+OFF_W-1:OFF_W];
  assign w_fire  = (wstate_q == W_DATA) && wready_q && s_axi_wvalid;

`ifdef AXI_MEM_ERR_RESP_EN
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * STRB_W);
  assign ar_oor = (s_axi_araddr >= MEM_BYTES);
  assign rn_oor = (raddr_d >= MEM_BYTES);
  assign w_oor  = (waddr_q >= MEM_BYTES);
  // wlast must be high on exactly the final counted beat.
  assign w_bad  = w_oor || (s_axi_wlast != (wcnt_q == wlen_q));
`else
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;
  assign ar_oor = 1'b0;
  assign rn_oor = 1'b0;
  assign w_oor  = 1'b0;
  assign w_bad  = 1'b0;
`endif

  // A beat presented while rst is high is part of an aborted burst.
  assign mem_we = w_fire && !w_oor && !rst;

  // Memory has no reset; nonblocking update means a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid && arready_q) begin
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
            rid_q     <= s_axi_arid;
            raddr_q   <= s_axi_araddr;
            rlen_q    <= s_axi_arlen;
            rsize_q   <= s_axi_arsize;
            rburst_q  <= s_axi_arburst;
            rcnt_q    <= 8'd0;
            rvalid_q  <= 1'b1;
            rlast_q   <= (s_axi_arlen == 8'd0);
            rdata_q   <= ar_oor ? '0 : mem_q[ar_idx];
            rresp_q   <= ar_oor ? 2'b10 : 2'b00;
          end
        end
        default: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rstate_q  <= R_IDLE;
              arready_q <= 1'b1;
            end else begin
              rcnt_q  <= rcnt_q + 8'd1;
              raddr_q <= raddr_d;
              rlast_q <= (rcnt_q + 8'd1 == rlen_q);
              rdata_q <= rn_oor ? '0 : mem_q[rn_idx];
              rresp_q <= rn_oor ? 2'b10 : 2'b00;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      werr_q    <= 1'b0;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_axi_awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_DATA;
            wid_q     <= s_axi_awid;
            waddr_q   <= s_axi_awaddr;
            wlen_q    <= s_axi_awlen;
            wsize_q   <= s_axi_awsize;
            wburst_q  <= s_axi_awburst;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            waddr_q <= waddr_d;
            werr_q  <= werr_q | w_bad;
            // Beat count, not wlast, closes the burst.
            if (wcnt_q == wlen_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= wid_q;
              bresp_q  <= (werr_q | w_bad) ? 2'b10 : 2'b00;
              wstate_q <= W_RESP;
            end else begin
              wcnt_q <= wcnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;

  logic        clk;
  logic        rst;
  logic        s_axi_arvalid, s_axi_arready;
  logic [3:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_rvalid, s_axi_rready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;

  axi_slave_mem #(.WIDTH(32), .ID_WIDTH(4), .ADDR_WIDTH(32), .MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_data [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input int id, input logic [31:0] addr, input int len, input int burst);
    int n;
    s_axi_awvalid = 1'b1; s_axi_awid = 4'(id); s_axi_awaddr = addr;
    s_axi_awlen = 8'(len); s_axi_awsize = 3'd2; s_axi_awburst = 2'(burst);
    n = 0;
    while (s_axi_awready !== 1'b1 && n < 20) begin step(); n++; end
    chk("aw_wait", s_axi_awready, 1);
    step();
    s_axi_awvalid = 1'b0;
    chk("wready_after_aw", s_axi_wready, 1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last;
    n = 0;
    while (s_axi_wready !== 1'b1 && n < 20) begin step(); n++; end
    chk("w_wait", s_axi_wready, 1);
    step();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  // Called right after the last W beat: B must already be valid.
  task automatic take_b(input int id, input int resp);
    chk("b_valid_latency", s_axi_bvalid, 1);
    chk("bid", s_axi_bid, 64'(id));
    chk("bresp", s_axi_bresp, 64'(resp));
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    chk("b_drop", s_axi_bvalid, 0);
  endtask

  task automatic send_ar(input int id, input logic [31:0] addr, input int len, input int burst);
    int n;
    s_axi_arvalid = 1'b1; s_axi_arid = 4'(id); s_axi_araddr = addr;
    s_axi_arlen = 8'(len); s_axi_arsize = 3'd2; s_axi_arburst = 2'(burst);
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 20) begin step(); n++; end
    chk("ar_wait", s_axi_arready, 1);
    step();
    s_axi_arvalid = 1'b0;
    chk("r_first_latency", s_axi_rvalid, 1);
  endtask

  // Accept `beats` R beats with rready held high, comparing against exp_data.
  task automatic take_r(input string tag, input int id, input int beats, input int resp);
    s_axi_rready = 1'b1;
    for (int i = 0; i < beats; i++) begin
      chk({tag, "_rvalid"}, s_axi_rvalid, 1);
      chk({tag, "_rdata"}, s_axi_rdata, 64'(exp_data[i]));
      chk({tag, "_rlast"}, s_axi_rlast, (i == beats - 1) ? 64'd1 : 64'd0);
      chk({tag, "_rid"}, s_axi_rid, 64'(id));
      chk({tag, "_rresp"}, s_axi_rresp, 64'(resp));
      step();
    end
    s_axi_rready = 1'b0;
    chk({tag, "_rvalid_drop"}, s_axi_rvalid, 0);
    chk({tag, "_arready_back"}, s_axi_arready, 1);
  endtask

  logic       bp_rdy  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] bp_dat [5] = '{32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2};
  logic       bp_last [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    s_axi_arvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
    s_axi_awvalid = 0; s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
    s_axi_rready = 0; s_axi_bready = 0;

    // Reset held for three cycles: every handshake signal low.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_handshakes", {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid}, 0);
      chk("rst_routputs", {s_axi_rdata, s_axi_rlast, s_axi_rresp, s_axi_rid}, 0);
      chk("rst_boutputs", {s_axi_bid, s_axi_bresp}, 0);
    end
    rst = 1'b0;
    step();
    chk("arready_after_rst", s_axi_arready, 1);
    chk("awready_after_rst", s_axi_awready, 1);

    // INCR write of four words at 0x10.
    send_aw(3, 32'h10, 3, 1);
    send_w(32'hA0, 4'hF, 1'b0);
    send_w(32'hA1, 4'hF, 1'b0);
    send_w(32'hA2, 4'hF, 1'b0);
    send_w(32'hA3, 4'hF, 1'b1);
    take_b(3, 0);

    // INCR read back.
    exp_data[0] = 32'hA0; exp_data[1] = 32'hA1; exp_data[2] = 32'hA2; exp_data[3] = 32'hA3;
    send_ar(3, 32'h10, 3, 1);
    take_r("incr", 3, 4, 0);

    // WRAP read from 0x18 over the 16-byte window at 0x10.
    exp_data[0] = 32'hA2; exp_data[1] = 32'hA3; exp_data[2] = 32'hA0; exp_data[3] = 32'hA1;
    send_ar(1, 32'h18, 3, 2);
    take_r("wrap", 1, 4, 0);

    // Backpressure: rready 1,0,0,1,1 over a 3-beat INCR read.
    send_ar(2, 32'h10, 2, 1);
    for (int i = 0; i < 5; i++) begin
      s_axi_rready = bp_rdy[i];
      chk("bp_rvalid", s_axi_rvalid, 1);
      chk("bp_rdata", s_axi_rdata, 64'(bp_dat[i]));
      chk("bp_rlast", s_axi_rlast, 64'(bp_last[i]));
      step();
    end
    s_axi_rready = 1'b0;
    chk("bp_rvalid_drop", s_axi_rvalid, 0);

    // Byte strobes: lanes 0 and 2 overwritten.
    send_aw(6, 32'h40, 0, 1);
    send_w(32'hFFFF_FFFF, 4'hF, 1'b1);
    take_b(6, 0);
    send_aw(7, 32'h40, 0, 1);
    send_w(32'h1234_5678, 4'b0101, 1'b1);
    take_b(7, 0);
    exp_data[0] = 32'hFF34_FF78;
    send_ar(8, 32'h40, 0, 1);
    take_r("strb", 8, 1, 0);

    // FIXED write: both beats hit 0x80, the second one sticks.
    send_aw(4, 32'h80, 1, 0);
    send_w(32'h1111_1111, 4'hF, 1'b0);
    send_w(32'h2222_2222, 4'hF, 1'b1);
    take_b(4, 0);
    exp_data[0] = 32'h2222_2222;
    send_ar(9, 32'h80, 0, 1);
    take_r("fixed", 9, 1, 0);

    // Reset in the middle of a write burst: no B, beats already written survive.
    send_aw(5, 32'h60, 3, 1);
    send_w(32'hB0, 4'hF, 1'b0);
    send_w(32'hB1, 4'hF, 1'b0);
    rst = 1'b1;
    step();
    chk("abort_bvalid", s_axi_bvalid, 0);
    chk("abort_wready", s_axi_wready, 0);
    chk("abort_awready", s_axi_awready, 0);
    rst = 1'b0;
    step();
    chk("abort_awready_back", s_axi_awready, 1);
    chk("abort_no_b", s_axi_bvalid, 0);
    exp_data[0] = 32'hB0; exp_data[1] = 32'hB1;
    send_ar(10, 32'h60, 1, 1);
    take_r("abort", 10, 2, 0);

`ifdef AXI_MEM_ERR_RESP_EN
    // Out-of-range accesses (memory is 0x400 bytes).
    exp_data[0] = 32'h0;
    send_ar(11, 32'h400, 0, 1);
    take_r("oor_read", 11, 1, 2);
    send_aw(12, 32'h400, 0, 1);
    send_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    take_b(12, 2);
    exp_data[0] = 32'hA0;
    send_ar(13, 32'h10, 0, 1);
    take_r("oor_nochange", 13, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
